branch_resolve_unit: RTL and testbench

Parametrised branch-condition resolver for the MIPS datapath. It replaces the fixed 4-way EQ/~EQ/GT/~GT select with the following:
- a full condition set, including signed and unsigned compare;
- target-address generation;
- a one-entry registered output stage with a valid/ready handshake;
- pipeline flush;
- saturating taken/resolved performance counters.

It sits between the ALU operand buses and the PC-source logic of the control unit.

---
 rtl/branch_resolve_unit.sv | 137 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch-condition resolver with a one-entry valid/ready output register,
// flush, and saturating taken/resolved performance counters.
module branch_resolve_unit #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       branch_op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] offset,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [WIDTH-1:0] out_target,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] resolved_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [2:0] OP_EQ = 3'b000;
  localparam logic [2:0] OP_NE = 3'b001;
  localparam logic [2:0] OP_GT = 3'b010;
  localparam logic [2:0] OP_LE = 3'b011;
  localparam logic [2:0] OP_LT = 3'b100;
  localparam logic [2:0] OP_GE = 3'b101;
  localparam logic [2:0] OP_AL = 3'b110;
  localparam logic [2:0] OP_NV = 3'b111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic             valid_q, valid_d;
  logic             taken_q, taken_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] tkn_cnt_q, tkn_cnt_d;

  logic             accept_s;
  logic             out_hs_s;
  logic             eq_s;
  logic             lt_s;
  logic             cond_s;
  logic [WIDTH-1:0] branch_tgt_s;

  assign in_ready = reset_n && !flush && (!valid_q || out_ready);
  assign accept_s = in_valid && in_ready;
  assign out_hs_s = valid_q && out_ready && !flush;

  // Evaluate the branch condition for the incoming request.
  always_comb begin
    eq_s = (op_a == op_b);
    if (is_signed) begin
      lt_s = ($signed(op_a) < $signed(op_b));
    end else begin
      lt_s = (op_a < op_b);
    end
    case (branch_op)
      OP_EQ:   cond_s = eq_s;
      OP_NE:   cond_s = !eq_s;
      OP_GT:   cond_s = !lt_s && !eq_s;
      OP_LE:   cond_s = lt_s || eq_s;
      OP_LT:   cond_s = lt_s;
      OP_GE:   cond_s = !lt_s;
      OP_AL:   cond_s = 1'b1;
      OP_NV:   cond_s = 1'b0;
      default: cond_s = 1'b0;
    endcase
    branch_tgt_s = pc_plus4 + (offset << SHIFT);
  end

  // Next state of the output register and counters; flush and clear win.
  always_comb begin
    valid_d   = valid_q;
    taken_d   = taken_q;
    target_d  = target_q;
    res_cnt_d = res_cnt_q;
    tkn_cnt_d = tkn_cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d  = 1'b1;
      taken_d  = cond_s;
      target_d = cond_s ? branch_tgt_s : pc_plus4;
    end else if (out_hs_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (clr_counts) begin
      res_cnt_d = {CNT_W{1'b0}};
      tkn_cnt_d = {CNT_W{1'b0}};
    end else if (out_hs_s) begin
      res_cnt_d = sat_inc(res_cnt_q);
      tkn_cnt_d = taken_q ? sat_inc(tkn_cnt_q) : tkn_cnt_q;
    end else begin
      res_cnt_d = res_cnt_q;
      tkn_cnt_d = tkn_cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= {WIDTH{1'b0}};
      res_cnt_q <= {CNT_W{1'b0}};
      tkn_cnt_q <= {CNT_W{1'b0}};
    end else begin
      valid_q   <= valid_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      res_cnt_q <= res_cnt_d;
      tkn_cnt_q <= tkn_cnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_taken      = taken_q;
  assign out_target     = target_q;
  assign resolved_count = res_cnt_q;
  assign taken_count    = tkn_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized bench for branch_resolve_unit against a
// behavioural model of the condition/target/handshake/counter rules.
module tb_branch_resolve_unit;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    branch_op;
  logic          is_signed;
  logic [W-1:0]  op_a, op_b, pc_plus4, offset;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          out_taken;
  logic [W-1:0]  out_target;
  logic          clr_counts;
  logic [CW-1:0] resolved_count;
  logic [CW-1:0] taken_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  bit          m_valid;
  bit          m_taken;
  logic [31:0] m_target;
  int          m_res;
  int          m_tkn;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(W), .SHIFT(2), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .branch_op(branch_op), .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
    .pc_plus4(pc_plus4), .offset(offset), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .clr_counts(clr_counts),
    .resolved_count(resolved_count), .taken_count(taken_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] op, input bit sgn,
                                  input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = sgn ? longint'({{32{a[31]}}, a}) : longint'({32'h0, a});
    sb = sgn ? longint'({{32{b[31]}}, b}) : longint'({32'h0, b});
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sa > sb;
      3'd3: return sa <= sb;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Apply current inputs for one clock, checking in_ready before and all outputs after.
  task automatic step();
    bit exp_ready, acc, hs, c;
    longint tgt;
    #1;
    exp_ready = reset_n && !flush && (!m_valid || out_ready);
    chk("in_ready", {63'h0, in_ready}, {63'h0, exp_ready});
    acc = in_valid && exp_ready;
    hs  = m_valid && out_ready && !flush;
    @(posedge clk);
    if (!reset_n) begin
      m_valid = 0; m_taken = 0; m_target = 32'h0; m_res = 0; m_tkn = 0;
    end else begin
      if (clr_counts) begin
        m_res = 0; m_tkn = 0;
      end else if (hs) begin
        if (m_res < CMAX) m_res++;
        if (m_taken && m_tkn < CMAX) m_tkn++;
      end
      if (flush) m_valid = 0;
      else if (acc) begin
        c = ref_cond(branch_op, is_signed, op_a, op_b);
        tgt = longint'({32'h0, pc_plus4}) + longint'({32'h0, offset}) * 4;
        m_valid = 1; m_taken = c;
        m_target = c ? tgt[31:0] : pc_plus4;
      end else if (hs) m_valid = 0;
    end
    #1;
    chk("out_valid",  {63'h0, out_valid}, {63'h0, m_valid});
    chk("out_taken",  {63'h0, out_taken}, {63'h0, m_taken});
    chk("out_target", {32'h0, out_target}, {32'h0, m_target});
    chk("resolved_count", {60'h0, resolved_count}, 64'(m_res));
    chk("taken_count",    {60'h0, taken_count},    64'(m_tkn));
  endtask

  task automatic set_req(input bit v, input logic [2:0] op, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] off);
    in_valid = v; branch_op = op; is_signed = sgn;
    op_a = a; op_b = b; pc_plus4 = pc; offset = off;
  endtask

  initial begin
    logic [31:0] held;
    reset_n = 1'b0; flush = 1'b0; clr_counts = 1'b0; out_ready = 1'b1;
    set_req(1'b1, 3'd6, 1'b0, 32'h0, 32'h0, 32'h40, 32'h1);
    m_valid = 0; m_taken = 0; m_target = 32'h0; m_res = 0; m_tkn = 0;

    // Reset, with a request, flush and clear presented concurrently
    step();
    flush = 1'b1; clr_counts = 1'b1;
    step();
    flush = 1'b0; clr_counts = 1'b0; in_valid = 1'b0;
    reset_n = 1'b1;
    #1 chk("ready_after_release", {63'h0, in_ready}, 64'h1);

    // Signed vs unsigned GT
    set_req(1'b1, 3'd2, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h100, 32'hFFFFFFFC);
    step();
    chk("gt_signed_taken",  {63'h0, out_taken}, 64'h0);
    chk("gt_signed_target", {32'h0, out_target}, 64'h100);
    is_signed = 1'b0;
    step();
    chk("gt_unsigned_taken",  {63'h0, out_taken}, 64'h1);
    chk("gt_unsigned_target", {32'h0, out_target}, 64'hF0);

    // Target wrap-around
    set_req(1'b1, 3'd0, 1'b0, 32'h1234, 32'h1234, 32'hFFFFFFF8, 32'h4);
    step();
    chk("wrap_taken",  {63'h0, out_taken}, 64'h1);
    chk("wrap_target", {32'h0, out_target}, 64'h8);

    // Back-pressure: the wrap result stays held for 3 cycles
    out_ready = 1'b0;
    set_req(1'b1, 3'd1, 1'b0, 32'h5, 32'h6, 32'h200, 32'h10);
    held = out_target;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_target", {32'h0, out_target}, {32'h0, held});
    end

    // Clear counters while draining, then 4 back-to-back requests
    out_ready = 1'b1; in_valid = 1'b0; clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 3'(i), 1'b1, 32'(i), 32'h2, 32'h1000 + 32'(i * 4), 32'h8);
      step();
      chk("b2b_valid", {63'h0, out_valid}, 64'h1);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_resolved", {60'h0, resolved_count}, 64'h4);

    // Flush with a held result, a ready consumer and a pending request
    set_req(1'b1, 3'd6, 1'b0, 32'h0, 32'h0, 32'h300, 32'h1);
    out_ready = 1'b0;
    step();
    out_ready = 1'b1; flush = 1'b1;
    set_req(1'b1, 3'd6, 1'b0, 32'h0, 32'h0, 32'h400, 32'h1);
    #1 chk("flush_in_ready", {63'h0, in_ready}, 64'h0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid",    {63'h0, out_valid}, 64'h0);
    chk("flush_resolved", {60'h0, resolved_count}, 64'h4);

    // Saturation: 17 taken handshakes with 4-bit counters
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    set_req(1'b1, 3'd6, 1'b0, 32'h0, 32'h0, 32'h500, 32'h2);
    for (int i = 0; i < 17; i++) step();
    in_valid = 1'b0;
    step();
    chk("sat_resolved", {60'h0, resolved_count}, 64'd15);
    chk("sat_taken",    {60'h0, taken_count},    64'd15);
    in_valid = 1'b1;
    step();
    clr_counts = 1'b1; in_valid = 1'b0;
    step();
    clr_counts = 1'b0;
    chk("clr_resolved", {60'h0, resolved_count}, 64'h0);
    chk("clr_taken",    {60'h0, taken_count},    64'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 3)) - 32'h2;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom()
                                              : 32'($urandom_range(0, 3)) - 32'h2);
      set_req($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              a, b, $urandom(), $urandom());
      out_ready  = $urandom_range(0, 3) != 0;
      flush      = $urandom_range(0, 15) == 0;
      clr_counts = $urandom_range(0, 63) == 0;
      reset_n    = $urandom_range(0, 99) != 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
